brick_field: RTL and testbench

- Parametrised brick-wall store and game-progress engine; successor to the fixed 64-entry, 2-bit brick array.
- Grid size, hit-point width and level count are configurable; supports multi-hit bricks, a level-load sequencer, a hit handshake from the ball logic, scoring, and a clear/win flag.
- Sits between ball collision logic (hit requests) and render (random-access reads), all in the 40 MHz pixel-clock domain.

---
 rtl/brick_field_if.sv | 13 +
 rtl/brick_field.sv | 174 +++++++++++++++++
 tb/tb_brick_field.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_field_if.sv
// Hit handshake between the ball collision logic (master) and the brick field (slave).
interface brick_field_if #(
  parameter int COL_W = 3,
  parameter int ROW_W = 3
);
  logic             hit_valid;
  logic [COL_W-1:0] hit_col;
  logic [ROW_W-1:0] hit_row;
  logic             hit_ready;

  modport master (output hit_valid, output hit_col, output hit_row, input hit_ready);
  modport slave  (input hit_valid, input hit_col, input hit_row, output hit_ready);
endinterface

// File: rtl/brick_field.sv
// Parametrised brick-wall store: level-load sequencer, multi-hit bricks, scoring
// and clear detection, with a combinational random-access read port for render.
module brick_field #(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int HP_W      = 2,
  parameter int LEVELS    = 4,
  parameter int BRICK_PTS = 10,
  parameter int SCORE_W   = 16,
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int CNT_W    = $clog2(ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [LVL_W-1:0]   level_sel_i,
  input  logic               score_clr_i,
  brick_field_if.slave       hit_if,
  input  logic [COL_W-1:0]   rd_col_i,
  input  logic [ROW_W-1:0]   rd_row_i,
  output logic [HP_W-1:0]    rd_hp_o,
  output logic [CNT_W-1:0]   remaining_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               busy_o,
  output logic               cleared_o
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IDX_W  = $clog2(NCELLS);
  localparam int HPMAX  = (2 ** HP_W) - 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [HP_W-1:0]    cell_q [NCELLS];
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ROW_W-1:0]   ld_row_q, ld_row_d;
  logic [COL_W-1:0]   ld_col_q, ld_col_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [HP_W-1:0]    wr_val;

  logic               hit_in_range, rd_in_range;
  logic [IDX_W-1:0]   hit_idx, rd_idx;
  logic [HP_W-1:0]    hit_hp;

  function automatic logic [IDX_W-1:0] cellIndex(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    int idx;
    idx = int'(row) * COLS + int'(col);
    return IDX_W'(idx);
  endfunction

  // Level pattern: diagonal stripes of empty cells, hp rising with row and level.
  function automatic logic [HP_W-1:0] patternHp(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col,
                                                input logic [LVL_W-1:0] lvl);
    int sum;
    int hp;
    sum = int'(row) + int'(col) + int'(lvl);
    hp  = ((int'(row) + int'(lvl)) % HPMAX) + 1;
    if ((sum % 4) == 3) return '0;
    return HP_W'(hp);
  endfunction

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] s,
                                                input logic [31:0]        pts);
    logic [SCORE_W+32:0] sum;
    sum = {33'd0, s} + {{(SCORE_W+1){1'b0}}, pts};
    if (sum > {33'd0, SCORE_MAX}) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  assign hit_in_range = (int'(hit_if.hit_row) < ROWS) && (int'(hit_if.hit_col) < COLS);
  assign hit_idx      = hit_in_range ? cellIndex(hit_if.hit_row, hit_if.hit_col) : '0;
  assign hit_hp       = hit_in_range ? cell_q[hit_idx] : '0;

  assign rd_in_range  = (int'(rd_row_i) < ROWS) && (int'(rd_col_i) < COLS);
  assign rd_idx       = rd_in_range ? cellIndex(rd_row_i, rd_col_i) : '0;
  assign rd_hp_o      = rd_in_range ? cell_q[rd_idx] : '0;

  assign hit_if.hit_ready = (state_q == S_PLAY);
  assign busy_o           = (state_q == S_LOAD);
  assign cleared_o        = (state_q == S_CLEAR);
  assign remaining_o      = remaining_q;
  assign score_o          = score_q;

  // A load pulse restarts the sequencer from any state and drops a concurrent hit.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    remaining_d = remaining_q;
    score_d     = score_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_val      = '0;

    if (load_i) begin
      state_d     = S_LOAD;
      level_d     = level_sel_i;
      ld_row_d    = '0;
      ld_col_d    = '0;
      remaining_d = '0;
      if (score_clr_i) score_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          wr_en  = 1'b1;
          wr_idx = cellIndex(ld_row_q, ld_col_q);
          wr_val = patternHp(ld_row_q, ld_col_q, level_q);
          if (wr_val != '0) remaining_d = remaining_q + 1'b1;
          if (int'(ld_col_q) == COLS - 1) begin
            ld_col_d = '0;
            if (int'(ld_row_q) == ROWS - 1) begin
              state_d = (remaining_d == '0) ? S_CLEAR : S_PLAY;
            end else begin
              ld_row_d = ld_row_q + 1'b1;
            end
          end else begin
            ld_col_d = ld_col_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (hit_if.hit_valid && hit_in_range && (hit_hp != '0)) begin
            wr_en  = 1'b1;
            wr_idx = hit_idx;
            wr_val = hit_hp - 1'b1;
            if (hit_hp == HP_W'(1)) begin
              remaining_d = remaining_q - 1'b1;
              score_d     = satAdd(score_q, 32'(BRICK_PTS));
              if (remaining_q == CNT_W'(1)) state_d = S_CLEAR;
            end else begin
              score_d = satAdd(score_q, 32'd1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      ld_row_q    <= '0;
      ld_col_q    <= '0;
      remaining_q <= '0;
      score_q     <= '0;
      for (int i = 0; i < NCELLS; i++) cell_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      ld_row_q    <= ld_row_d;
      ld_col_q    <= ld_col_d;
      remaining_q <= remaining_d;
      score_q     <= score_d;
      if (wr_en) cell_q[wr_idx] <= wr_val;
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: three instances (8x8 default, 2x2, 8x6 with
// a 4-bit score) driven from a table of hits with a queue of expected results.
module tb_brick_field;

  logic clk;
  logic rst;

  // Unit A: defaults (8x8, 4 levels, 16-bit score)
  logic       loadA, sclrA;
  logic [1:0] levelA;
  logic [2:0] rdRowA, rdColA;
  logic [1:0] rdHpA;
  logic [6:0] remA;
  logic [15:0] scoreA;
  logic       busyA, clearedA;

  // Unit B: 2x2, 2 levels
  logic       loadB, sclrB;
  logic [0:0] levelB;
  logic [0:0] rdRowB, rdColB;
  logic [1:0] rdHpB;
  logic [2:0] remB;
  logic [15:0] scoreB;
  logic       busyB, clearedB;

  // Unit C: 8 rows x 6 cols, 4-bit score
  logic       loadC, sclrC;
  logic [1:0] levelC;
  logic [2:0] rdRowC, rdColC;
  logic [1:0] rdHpC;
  logic [5:0] remC;
  logic [3:0] scoreC;
  logic       busyC, clearedC;

  brick_field_if #(.COL_W(3), .ROW_W(3)) ifA ();
  brick_field_if #(.COL_W(1), .ROW_W(1)) ifB ();
  brick_field_if #(.COL_W(3), .ROW_W(3)) ifC ();

  brick_field dutA (
    .clk(clk), .rst(rst), .load_i(loadA), .level_sel_i(levelA), .score_clr_i(sclrA),
    .hit_if(ifA), .rd_col_i(rdColA), .rd_row_i(rdRowA), .rd_hp_o(rdHpA),
    .remaining_o(remA), .score_o(scoreA), .busy_o(busyA), .cleared_o(clearedA)
  );

  brick_field #(.COLS(2), .ROWS(2), .LEVELS(2)) dutB (
    .clk(clk), .rst(rst), .load_i(loadB), .level_sel_i(levelB), .score_clr_i(sclrB),
    .hit_if(ifB), .rd_col_i(rdColB), .rd_row_i(rdRowB), .rd_hp_o(rdHpB),
    .remaining_o(remB), .score_o(scoreB), .busy_o(busyB), .cleared_o(clearedB)
  );

  brick_field #(.COLS(6), .ROWS(8), .SCORE_W(4)) dutC (
    .clk(clk), .rst(rst), .load_i(loadC), .level_sel_i(levelC), .score_clr_i(sclrC),
    .hit_if(ifC), .rd_col_i(rdColC), .rd_row_i(rdRowC), .rd_hp_o(rdHpC),
    .remaining_o(remC), .score_o(scoreC), .busy_o(busyC), .cleared_o(clearedC)
  );

  typedef struct {
    int unit;
    int row;
    int col;
    int expHp;
    int expRem;
    int expScore;
    int expCleared;
    int expReady;
  } hitVec_t;

  hitVec_t vecs[$];
  hitVec_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic clearHits();
    ifA.hit_valid = 1'b0;
    ifB.hit_valid = 1'b0;
    ifC.hit_valid = 1'b0;
  endtask

  // Drives one hit on the selected unit and points its read port at the same cell.
  task automatic applyStimulus(input int unit, input int row, input int col);
    clearHits();
    case (unit)
      0: begin
        ifA.hit_valid = 1'b1; ifA.hit_row = 3'(row); ifA.hit_col = 3'(col);
        rdRowA = 3'(row); rdColA = 3'(col);
      end
      1: begin
        ifB.hit_valid = 1'b1; ifB.hit_row = 1'(row); ifB.hit_col = 1'(col);
        rdRowB = 1'(row); rdColB = 1'(col);
      end
      default: begin
        ifC.hit_valid = 1'b1; ifC.hit_row = 3'(row); ifC.hit_col = 3'(col);
        rdRowC = 3'(row); rdColC = 3'(col);
      end
    endcase
  endtask

  task automatic checkHit(input hitVec_t e);
    int hp, rem, sc, clr, rdy;
    string tag;
    hp = 0; rem = 0; sc = 0; clr = 0; rdy = 0;
    case (e.unit)
      0: begin hp = int'(rdHpA); rem = int'(remA); sc = int'(scoreA); clr = int'(clearedA); rdy = int'(ifA.hit_ready); end
      1: begin hp = int'(rdHpB); rem = int'(remB); sc = int'(scoreB); clr = int'(clearedB); rdy = int'(ifB.hit_ready); end
      default: begin hp = int'(rdHpC); rem = int'(remC); sc = int'(scoreC); clr = int'(clearedC); rdy = int'(ifC.hit_ready); end
    endcase
    tag = $sformatf("unit%0d hit(%0d,%0d)", e.unit, e.row, e.col);
    checkOutput({tag, " hp"}, hp, e.expHp);
    checkOutput({tag, " remaining"}, rem, e.expRem);
    checkOutput({tag, " score"}, sc, e.expScore);
    checkOutput({tag, " cleared"}, clr, e.expCleared);
    checkOutput({tag, " hit_ready"}, rdy, e.expReady);
  endtask

  // Waits for unit A's load to finish, returning the number of busy cycles seen.
  task automatic waitLoadA(output int cnt);
    cnt = 0;
    while (busyA && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cntA, cntB, cntC;

    // unit, row, col, hp, remaining, score, cleared, ready
    vecs.push_back('{0, 0, 0, 0, 47, 10, 0, 1});
    vecs.push_back('{0, 1, 0, 1, 47, 11, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 46, 21, 0, 1});
    vecs.push_back('{0, 0, 3, 0, 46, 21, 0, 1});
    vecs.push_back('{0, 2, 0, 2, 46, 22, 0, 1});
    vecs.push_back('{0, 2, 0, 1, 46, 23, 0, 1});
    vecs.push_back('{0, 2, 0, 0, 45, 33, 0, 1});
    vecs.push_back('{0, 3, 0, 0, 45, 33, 0, 1});
    vecs.push_back('{0, 3, 1, 0, 44, 43, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 3, 10, 0, 1});
    vecs.push_back('{1, 0, 1, 0, 2, 20, 0, 1});
    vecs.push_back('{1, 1, 0, 1, 2, 21, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 1, 31, 0, 1});
    vecs.push_back('{1, 1, 1, 1, 1, 32, 0, 1});
    vecs.push_back('{1, 1, 1, 0, 0, 42, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 42, 1, 0});
    vecs.push_back('{2, 1, 0, 1, 36, 1, 0, 1});
    vecs.push_back('{2, 1, 0, 0, 35, 11, 0, 1});
    vecs.push_back('{2, 1, 1, 1, 35, 12, 0, 1});
    vecs.push_back('{2, 1, 3, 1, 35, 13, 0, 1});
    vecs.push_back('{2, 1, 4, 1, 35, 14, 0, 1});
    vecs.push_back('{2, 0, 7, 0, 35, 14, 0, 1});
    vecs.push_back('{2, 0, 0, 0, 34, 15, 0, 1});

    rst = 1'b1;
    loadA = 0; sclrA = 0; levelA = '0; rdRowA = '0; rdColA = '0;
    loadB = 0; sclrB = 0; levelB = '0; rdRowB = '0; rdColB = '0;
    loadC = 0; sclrC = 0; levelC = '0; rdRowC = '0; rdColC = '0;
    clearHits();
    ifA.hit_row = '0; ifA.hit_col = '0;
    ifB.hit_row = '0; ifB.hit_col = '0;
    ifC.hit_row = '0; ifC.hit_col = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset remaining", int'(remA), 0);
    checkOutput("reset score", int'(scoreA), 0);
    checkOutput("reset busy", int'(busyA), 0);
    checkOutput("reset cleared", int'(clearedA), 0);
    checkOutput("reset hit_ready", int'(ifA.hit_ready), 0);
    checkOutput("reset rd_hp", int'(rdHpA), 0);

    // Load level 0 on all units together and count busy cycles.
    loadA = 1; loadB = 1; loadC = 1; sclrA = 1; sclrB = 1; sclrC = 1;
    @(negedge clk);
    loadA = 0; loadB = 0; loadC = 0; sclrA = 0; sclrB = 0; sclrC = 0;
    cntA = 0; cntB = 0; cntC = 0;
    for (int k = 0; k < 100; k++) begin
      if (busyA) cntA++;
      if (busyB) cntB++;
      if (busyC) cntC++;
      @(negedge clk);
    end
    checkOutput("A busy cycles", cntA, 64);
    checkOutput("B busy cycles", cntB, 4);
    checkOutput("C busy cycles", cntC, 48);
    checkOutput("A loaded remaining", int'(remA), 48);
    checkOutput("B loaded remaining", int'(remB), 4);
    checkOutput("C loaded remaining", int'(remC), 36);
    checkOutput("A hit_ready in play", int'(ifA.hit_ready), 1);
    rdRowA = 3'd0; rdColA = 3'd0; #1;
    checkOutput("A rd_hp(0,0)", int'(rdHpA), 1);
    rdRowA = 3'd1; rdColA = 3'd0; #1;
    checkOutput("A rd_hp(1,0)", int'(rdHpA), 2);
    rdRowA = 3'd0; rdColA = 3'd3; #1;
    checkOutput("A rd_hp(0,3)", int'(rdHpA), 0);

    // Table of hits, back-to-back per unit; each result is checked a cycle later.
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (expQ.size() > 0) checkHit(expQ.pop_front());
      if (i < vecs.size()) begin
        applyStimulus(vecs[i].unit, vecs[i].row, vecs[i].col);
        expQ.push_back(vecs[i]);
      end else begin
        clearHits();
      end
    end

    // Load in the same cycle as a hit on an untouched brick: the hit is dropped.
    @(negedge clk);
    loadA = 1; levelA = 2'd2; sclrA = 0;
    applyStimulus(0, 1, 1);
    @(negedge clk);
    loadA = 0;
    clearHits();
    checkOutput("load beats hit score", int'(scoreA), 43);
    checkOutput("busy after load", int'(busyA), 1);
    checkOutput("hit_ready during load", int'(ifA.hit_ready), 0);

    // Restart the load partway through with level 1.
    repeat (19) @(negedge clk);
    checkOutput("busy mid load", int'(busyA), 1);
    loadA = 1; levelA = 2'd1;
    @(negedge clk);
    loadA = 0;
    waitLoadA(cntA);
    checkOutput("restart busy cycles", cntA, 64);
    rdRowA = 3'd0; rdColA = 3'd0; #1;
    checkOutput("level1 rd_hp(0,0)", int'(rdHpA), 2);
    rdRowA = 3'd0; rdColA = 3'd2; #1;
    checkOutput("level1 rd_hp(0,2)", int'(rdHpA), 0);
    checkOutput("level1 remaining", int'(remA), 48);
    checkOutput("score kept on load", int'(scoreA), 43);

    @(negedge clk);
    loadA = 1; levelA = 2'd0; sclrA = 1;
    @(negedge clk);
    loadA = 0; sclrA = 0;
    checkOutput("score cleared on load", int'(scoreA), 0);
    waitLoadA(cntA);
    checkOutput("reload busy cycles", cntA, 64);
    checkOutput("reload remaining", int'(remA), 48);

    applyStimulus(0, 0, 0);
    @(negedge clk);
    clearHits();
    checkOutput("post-reload hit score", int'(scoreA), 10);

    // Asynchronous reset in the middle of a cycle while A and C are in play.
    rdRowA = 3'd1; rdColA = 3'd0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst A score", int'(scoreA), 0);
    checkOutput("async rst A remaining", int'(remA), 0);
    checkOutput("async rst A hit_ready", int'(ifA.hit_ready), 0);
    checkOutput("async rst A busy", int'(busyA), 0);
    checkOutput("async rst A rd_hp", int'(rdHpA), 0);
    checkOutput("async rst B cleared", int'(clearedB), 0);
    checkOutput("async rst C score", int'(scoreC), 0);
    checkOutput("async rst C remaining", int'(remC), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
